counter_ctrl: RTL and testbench

Front-panel control stage that sits directly upstream of `tt_um_up_down_counter`. It turns raw, bouncy push-buttons and a 4-bit switch bank into the counter's `enable`, `up_down`, `set` and `set_value` controls. Each button passes through a 2-flop synchronizer and a debounce filter. Debounced presses drive a 4-state run-mode FSM. The counter's `count` output feeds back so the block can optionally stop at the terminal value.

---
 rtl/counter_ctrl.sv | 156 +++++++++++++++
 tb/tb_counter_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: front-panel control for tt_um_up_down_counter.
// Each raw button is synchronised and debounced. Press edges drive a
// four-state run-mode FSM that produces the counter's enable, up_down,
// set and set_value controls.
// Optional feature macro: COUNTER_CTRL_AUTOSTOP_EN. When it is defined,
// enable is forced low at the terminal count and the FSM returns to IDLE.
// When it is undefined, count_in is ignored and the counter wraps freely.
module counter_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_stop,
    input  logic       btn_load,
    input  logic [3:0] load_value,
    input  logic [3:0] count_in,
    output logic       enable,
    output logic       up_down,
    output logic       set,
    output logic [3:0] set_value,
    output logic [1:0] state
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned NUM_BTN  = 4;
    localparam int unsigned BTN_UP   = 0;
    localparam int unsigned BTN_DOWN = 1;
    localparam int unsigned BTN_STOP = 2;
    localparam int unsigned BTN_LOAD = 3;

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] RUN_UP   = 2'b01;
    localparam logic [1:0] RUN_DOWN = 2'b10;
    localparam logic [1:0] LOAD     = 2'b11;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync_s1;
    logic [NUM_BTN-1:0] sync_s2;
    logic [NUM_BTN-1:0] db;
    logic [NUM_BTN-1:0] db_q;
    logic [NUM_BTN-1:0] press;
    logic [CNT_W-1:0]   cnt [NUM_BTN];

    logic [1:0] next_state;
    logic       enable_q;
    logic       at_limit;

    assign btn_raw = {btn_load, btn_stop, btn_down, btn_up};

    // Two-flop synchronisers for the asynchronous buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= btn_raw;
            sync_s2 <= sync_s1;
        end
    end

    // Debounce: accept a new level only after it has been stable long enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync_s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]  <= sync_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Delayed debounced level, used to detect press edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= '0;
        end else begin
            db_q <= db;
        end
    end

    assign press = db & ~db_q;

`ifdef COUNTER_CTRL_AUTOSTOP_EN
    // Terminal count in the current run direction
    assign at_limit = ((state == RUN_UP)   && (count_in == 4'hF)) ||
                      ((state == RUN_DOWN) && (count_in == 4'h0));
    assign enable   = enable_q & ~at_limit;
`else
    logic unused_count_in;

    assign at_limit        = 1'b0;
    assign enable          = enable_q;
    assign unused_count_in = ^count_in;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: presses take priority stop > load > up > down
    always_comb begin
        next_state = state;
        if (press[BTN_STOP]) begin
            next_state = IDLE;
        end else if (press[BTN_LOAD]) begin
            next_state = LOAD;
        end else if (press[BTN_UP]) begin
            next_state = RUN_UP;
        end else if (press[BTN_DOWN]) begin
            next_state = RUN_DOWN;
        end else if (state == LOAD) begin
            next_state = IDLE;
        end else if (at_limit) begin
            next_state = IDLE;
        end
    end

    // Registered outputs derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q  <= 1'b0;
            up_down   <= 1'b0;
            set       <= 1'b0;
            set_value <= 4'h0;
        end else begin
            enable_q <= (next_state == RUN_UP) || (next_state == RUN_DOWN);
            set      <= (next_state == LOAD);
            if (next_state == RUN_UP) begin
                up_down <= 1'b1;
            end else if (next_state == RUN_DOWN) begin
                up_down <= 1'b0;
            end
            if (press[BTN_LOAD] && !press[BTN_STOP]) begin
                set_value <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl with DEBOUNCE_CYCLES=4: table of directed
// button vectors plus hand-written edge-by-edge sequences.
module tb_counter_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_stop;
    logic       btn_load;
    logic [3:0] load_value;
    logic [3:0] count_in;
    logic       enable;
    logic       up_down;
    logic       set;
    logic [3:0] set_value;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

`ifdef COUNTER_CTRL_AUTOSTOP_EN
    localparam bit AS = 1'b1;
`else
    localparam bit AS = 1'b0;
`endif

    counter_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_stop   (btn_stop),
        .btn_load   (btn_load),
        .load_value (load_value),
        .count_in   (count_in),
        .enable     (enable),
        .up_down    (up_down),
        .set        (set),
        .set_value  (set_value),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // btn field order: {load, stop, down, up}
    typedef struct {
        string      name;
        logic [3:0] btn;
        int         hold;
        logic [3:0] lv;
        logic [3:0] ci;
        logic [1:0] st;
        logic       en;
        logic       ud;
        logic [3:0] sv;
    } vec_t;

    vec_t tbl [16];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        load_value = v.lv;
        count_in   = v.ci;
        {btn_load, btn_stop, btn_down, btn_up} = v.btn;
        repeat (v.hold) tick();
        {btn_load, btn_stop, btn_down, btn_up} = 4'b0000;
        repeat (10) tick();
        chk({v.name, ".state"}, 8'(state), 8'(v.st));
        chk({v.name, ".enable"}, 8'(enable), 8'(v.en));
        chk({v.name, ".up_down"}, 8'(up_down), 8'(v.ud));
        chk({v.name, ".set"}, 8'(set), 8'h00);
        chk({v.name, ".set_value"}, 8'(set_value), 8'(v.sv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{"stop",        4'b0100, 10, 4'h0, 4'h7, 2'b00, 1'b0, 1'b1, 4'h0};
        tbl[1]  = '{"up",          4'b0001, 10, 4'h0, 4'h7, 2'b01, 1'b1, 1'b1, 4'h0};
        tbl[2]  = '{"down_glitch", 4'b0010,  3, 4'h0, 4'h7, 2'b01, 1'b1, 1'b1, 4'h0};
        tbl[3]  = '{"down",        4'b0010,  8, 4'h0, 4'h7, 2'b10, 1'b1, 1'b0, 4'h0};
        tbl[4]  = '{"up_glitch",   4'b0001,  2, 4'h0, 4'h7, 2'b10, 1'b1, 1'b0, 4'h0};
        tbl[5]  = '{"down_again",  4'b0010, 10, 4'h0, 4'h7, 2'b10, 1'b1, 1'b0, 4'h0};
        tbl[6]  = '{"stop_up",     4'b0101, 10, 4'h0, 4'h7, 2'b00, 1'b0, 1'b0, 4'h0};
        tbl[7]  = '{"idle_down",   4'b0010, 10, 4'h0, 4'h7, 2'b10, 1'b1, 1'b0, 4'h0};
        tbl[8]  = '{"down_to_up",  4'b0001, 10, 4'h0, 4'h7, 2'b01, 1'b1, 1'b1, 4'h0};
        tbl[9]  = '{"load_up",     4'b1001, 10, 4'h5, 4'h7, 2'b00, 1'b0, 1'b1, 4'h5};
        tbl[10] = '{"up_down_tie", 4'b0011, 10, 4'h0, 4'h7, 2'b01, 1'b1, 1'b1, 4'h5};
        tbl[11] = '{"to_down",     4'b0010, 10, 4'h0, 4'h7, 2'b10, 1'b1, 1'b0, 4'h5};
        tbl[12] = '{"to_up",       4'b0001, 10, 4'h0, 4'h7, 2'b01, 1'b1, 1'b1, 4'hA};
        tbl[13] = '{"stop_ci0",    4'b0100, 10, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 4'hA};
        tbl[14] = '{"down_ci0",    4'b0010, 10, 4'h0, 4'h0,
                    AS ? 2'b00 : 2'b10, AS ? 1'b0 : 1'b1, 1'b0, 4'hA};
        tbl[15] = '{"down_ci7",    4'b0010, 10, 4'h0, 4'h7, 2'b10, 1'b1, 1'b0, 4'hA};

        // Reset with up and down held; up must win exactly 7 edges after release
        rst_n = 1'b0;
        btn_up = 1'b1; btn_down = 1'b1; btn_stop = 1'b0; btn_load = 1'b0;
        load_value = 4'h0; count_in = 4'h7;
        repeat (3) tick();
        chk("rst.state", 8'(state), 8'h00);
        chk("rst.enable", 8'(enable), 8'h00);
        chk("rst.up_down", 8'(up_down), 8'h00);
        chk("rst.set", 8'(set), 8'h00);
        chk("rst.set_value", 8'(set_value), 8'h00);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("rel.enable.e%0d", e), 8'(enable), 8'h00);
            chk($sformatf("rel.state.e%0d", e), 8'(state), 8'h00);
        end
        tick();
        chk("rel.enable.e7", 8'(enable), 8'h01);
        chk("rel.up_down.e7", 8'(up_down), 8'h01);
        chk("rel.state.e7", 8'(state), 8'h01);
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (10) tick();

        for (int i = 0; i <= 11; i++) apply_vec(tbl[i]);

        // Load press from RUN_DOWN: one-cycle set pulse, then IDLE
        load_value = 4'hA;
        btn_load = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("ld.set.e%0d", e), 8'(set), 8'h00);
            chk($sformatf("ld.state.e%0d", e), 8'(state), 8'h02);
        end
        tick();
        chk("ld.set.e7", 8'(set), 8'h01);
        chk("ld.set_value.e7", 8'(set_value), 8'h0A);
        chk("ld.enable.e7", 8'(enable), 8'h00);
        chk("ld.state.e7", 8'(state), 8'h03);
        tick();
        chk("ld.set.e8", 8'(set), 8'h00);
        chk("ld.state.e8", 8'(state), 8'h00);
        chk("ld.enable.e8", 8'(enable), 8'h00);
        load_value = 4'h3;
        repeat (3) tick();
        btn_load = 1'b0;
        repeat (10) tick();
        chk("ld.set_value.hold", 8'(set_value), 8'h0A);

        apply_vec(tbl[12]);

        // Terminal count while running up
        count_in = 4'hE;
        tick();
        chk("as.enable.E", 8'(enable), 8'h01);
        chk("as.state.E", 8'(state), 8'h01);
        count_in = 4'hF;
        #1;
        chk("as.enable.F", 8'(enable), AS ? 8'h00 : 8'h01);
        chk("as.state.F", 8'(state), 8'h01);
        tick();
        chk("as.state.next", 8'(state), AS ? 8'h00 : 8'h01);
        chk("as.enable.next", 8'(enable), AS ? 8'h00 : 8'h01);
        btn_up = 1'b1;
        repeat (7) tick();
        chk("as.reup.state", 8'(state), 8'h01);
        chk("as.reup.enable", 8'(enable), AS ? 8'h00 : 8'h01);
        tick();
        chk("as.reup.state.next", 8'(state), AS ? 8'h00 : 8'h01);
        btn_up = 1'b0;
        repeat (10) tick();

        for (int i = 13; i <= 15; i++) apply_vec(tbl[i]);

        // Asynchronous reset between clock edges
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.state", 8'(state), 8'h00);
        chk("arst.enable", 8'(enable), 8'h00);
        chk("arst.up_down", 8'(up_down), 8'h00);
        chk("arst.set_value", 8'(set_value), 8'h00);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
